// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared state encoding and default widths for the counter sequencer.
package counter_pkg;

    localparam int CNT_W = 4;
    localparam int PRE_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        DONE
    } seq_state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// rtl/counter_sequencer_if.sv - run control and downstream counter signals of the sequencer.
interface counter_sequencer_if
    import counter_pkg::*;
#(
    parameter int N  = CNT_W,
    parameter int PW = PRE_W
);

    logic          start;
    logic          stop;
    logic [N-1:0]  preset;
    logic [N-1:0]  target;
    logic [PW-1:0] div;
    logic [N-1:0]  q_in;
    logic [N-1:0]  d;
    logic          load;
    logic          en;
    logic          busy;
    logic          done;

    modport master (
        output start, stop, preset, target, div, q_in,
        input  d, load, en, busy, done
    );

    modport slave (
        input  start, stop, preset, target, div, q_in,
        output d, load, en, busy, done
    );

endinterface

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - divide-by-(divisor+1) tick generator gated by enable.
module tick_prescaler
    import counter_pkg::*;
#(
    parameter int PW = PRE_W
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [PW-1:0] divisor,
    output logic          tick
);

    logic [PW-1:0] count;

    assign tick = enable && (count == divisor);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= tick ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/counter_sequencer.sv
// rtl/counter_sequencer.sv - load-and-count sequencer for an external counter; SEQ_AUTO_RELOAD_EN repeats runs until stop.
module counter_sequencer
    import counter_pkg::*;
#(
    parameter int N  = CNT_W,
    parameter int PW = PRE_W
) (
    input  logic                 clk,
    input  logic                 reset,
    counter_sequencer_if.slave   bus
);

    seq_state_t    state;
    seq_state_t    next_state;
    logic [N-1:0]  preset_q;
    logic [N-1:0]  target_q;
    logic [PW-1:0] div_q;
    logic          tick;
    logic          match;

    assign match = (bus.q_in == target_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            preset_q <= '0;
            target_q <= '0;
            div_q    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && bus.start) begin
                preset_q <= bus.preset;
                target_q <= bus.target;
                div_q    <= bus.div;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (bus.start) next_state = LOAD;
`ifdef SEQ_AUTO_RELOAD_EN
            LOAD: next_state = bus.stop ? IDLE : RUN;
`else
            LOAD: next_state = RUN;
`endif
            // stop wins over a target match in the same cycle
            RUN: begin
                if (bus.stop)  next_state = IDLE;
                else if (match) next_state = DONE;
            end
`ifdef SEQ_AUTO_RELOAD_EN
            DONE: next_state = bus.stop ? IDLE : LOAD;
`else
            DONE: next_state = IDLE;
`endif
            default: next_state = IDLE;
        endcase
    end

    tick_prescaler #(.PW(PW)) u_prescaler (
        .clk     (clk),
        .reset   (reset),
        .clear   (state == LOAD),
        .enable  (state == RUN),
        .divisor (div_q),
        .tick    (tick)
    );

    assign bus.load = (state == LOAD);
    assign bus.en   = tick && !match;
    assign bus.done = (state == DONE);
    assign bus.d    = (state == IDLE) ? '0 : preset_q;
`ifdef SEQ_AUTO_RELOAD_EN
    assign bus.busy = (state != IDLE);
`else
    assign bus.busy = (state == LOAD) || (state == RUN);
`endif

endmodule

// File: tb/tb_counter_sequencer.sv
// tb/tb_counter_sequencer.sv - self-checking bench for counter_sequencer against a run-length model.
module tb_counter_sequencer;
    import counter_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [3:0] q  = 4'd0;

    always #5 clk = ~clk;

    counter_sequencer_if #(.N(4), .PW(8)) bus ();

    counter_sequencer #(.N(4), .PW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // downstream counter that the sequencer drives
    always @(posedge clk) begin
        if (bus.load)    q <= bus.d;
        else if (bus.en) q <= q + 4'd1;
    end
    assign bus.q_in = q;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_load"}, bus.load, 0);
        chk({tag, "_en"},   bus.en,   0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_d"},    bus.d,    0);
    endtask

    // Called at a negedge with the sequencer idle; pulses expected at RUN index j where
    // j mod (div+1) == div, for (target-preset) mod 16 pulses, then one match cycle.
    task automatic run_case(input logic [3:0] p, input logic [3:0] t, input int dv, input int stop_pulse);
        int k, runs, pulses;
        logic exp_en;
        bus.preset = p; bus.target = t; bus.div = dv[7:0]; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start  = 1'b0;
        bus.preset = 4'($urandom); bus.target = 4'($urandom); bus.div = 8'($urandom);
        @(negedge clk);
        chk("load_strobe", bus.load, 1);
        chk("load_d",      bus.d,    p);
        chk("load_en",     bus.en,   0);
        chk("load_busy",   bus.busy, 1);
        k      = int'(4'(t - p));
        runs   = k * (dv + 1) + 1;
        pulses = 0;
        for (int j = 0; j < runs; j++) begin
            @(posedge clk); #1;
            bus.start = 1'($urandom);
            @(negedge clk);
            exp_en = (j < runs - 1) && ((j % (dv + 1)) == dv);
            chk("run_en",   bus.en,   exp_en);
            chk("run_load", bus.load, 0);
            chk("run_busy", bus.busy, 1);
            chk("run_done", bus.done, 0);
            chk("run_d",    bus.d,    p);
            if (exp_en) pulses++;
            if (exp_en && pulses == stop_pulse) begin
                @(posedge clk); #1;
                bus.start = 1'b0; bus.stop = 1'b1;
                @(negedge clk);
                chk("stop_en",   bus.en,   0);
                chk("stop_busy", bus.busy, 1);
                @(posedge clk); #1;
                bus.stop = 1'b0;
                @(negedge clk);
                chk_idle("after_stop");
                @(posedge clk); #1;
                @(negedge clk);
                chk_idle("after_stop2");
                return;
            end
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.stop = 1'b1;
        @(negedge clk);
        chk("done_pulse", bus.done, 1);
        chk("done_en",    bus.en,   0);
        chk("done_load",  bus.load, 0);
        chk("done_q",     q,        t);
        chk("done_pulses", pulses,  k);
`ifdef SEQ_AUTO_RELOAD_EN
        chk("done_busy",  bus.busy, 1);
`else
        chk("done_busy",  bus.busy, 0);
`endif
        @(posedge clk); #1;
        bus.stop = 1'b0;
        @(negedge clk);
        chk_idle("post_done");
    endtask

    initial begin
        int dv, k, sp;
        logic [3:0] p, t;
        bus.start = 1'b1; bus.stop = 1'b0;
        bus.preset = 4'hA; bus.target = 4'hD; bus.div = 8'd0;

        repeat (2) begin
            @(negedge clk);
            chk_idle("in_reset");
        end
        reset = 1'b1;

        run_case(4'b1010, 4'b1101, 0, -1);
        run_case(4'b0000, 4'b0010, 3, -1);
        run_case(4'b1110, 4'b0001, 0, -1);
        run_case(4'b0000, 4'b1001, 1, 1);
        run_case(4'b0101, 4'b0101, 0, -1);

        for (int i = 0; i < 10; i++) begin
            p  = 4'($urandom);
            t  = 4'($urandom);
            dv = int'($urandom_range(0, 3));
            k  = int'(4'(t - p));
            sp = (dv > 0 && k > 1 && $urandom_range(0, 1) == 1) ? 1 : -1;
            run_case(p, t, dv, sp);
        end

        // asynchronous reset in the middle of a run
        bus.preset = 4'h0; bus.target = 4'hF; bus.div = 8'd2; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        chk_idle("async_reset");
        @(negedge clk);
        chk_idle("reset_hold");
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_idle("after_reset");
        end

`ifdef SEQ_AUTO_RELOAD_EN
        bus.preset = 4'h5; bus.target = 4'h5; bus.div = 8'd0; bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("reload_load", bus.load, (i % 3) == 0);
            chk("reload_done", bus.done, (i % 3) == 2);
            chk("reload_busy", bus.busy, 1);
            @(posedge clk); #1;
        end
        bus.stop = 1'b1;
        @(negedge clk);
        chk("reload_last_load", bus.load, 1);
        @(posedge clk); #1;
        bus.stop = 1'b0;
        @(negedge clk);
        chk_idle("reload_stopped");
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

Interface
REQ-001 Parameter N, default 4, width of counter data, preset, target and feedback.
REQ-002 Parameter PW, default 8, width of prescale divisor and prescale counter.
REQ-003 clk  input  1  rising-edge clock shared with the downstream counter.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  level, sampled in IDLE; begins a load-and-count run.
REQ-006 stop  input  1  level; aborts a run in RUN.
REQ-007 preset  input  N  value loaded into the counter at run start.
REQ-008 target  input  N  counter value that ends a run.
REQ-009 div  input  PW  prescale divisor; one en pulse every div+1 RUN cycles.
REQ-010 q_in  input  N  counter output fed back.
REQ-011 d  output  N  counter load data.
REQ-012 load  output  1  counter synchronous load strobe.
REQ-013 en  output  1  counter count-enable pulse.
REQ-014 busy  output  1  high in LOAD and RUN.
REQ-015 done  output  1  single-cycle pulse on target reached.

Function
REQ-016 FSM states IDLE, LOAD, RUN, DONE; one state transition per clk edge.
REQ-017 IDLE: start=1 -> LOAD; otherwise stay; preset, target, div captured into internal registers on that edge.
REQ-018 LOAD: load=1, d=captured preset, en=0, prescale counter cleared to 0; unconditionally -> RUN.
REQ-019 RUN: en=1 exactly when prescale counter == captured div; prescale counter then returns to 0, else increments by 1.
REQ-020 div=0: en=1 on every RUN cycle.
REQ-021 RUN: q_in == captured target -> DONE, en=0 that cycle; match checked every RUN cycle, including the first.
REQ-022 preset == target: run ends after one RUN cycle with zero en pulses.
REQ-023 RUN: stop=1 -> IDLE, en=0, done not asserted; stop takes priority over target match.
REQ-024 DONE: done=1 for one cycle -> IDLE.
REQ-025 start ignored outside IDLE; input changes during a run have no effect (captured values used).
REQ-026 Counter wrap (2**N-1 -> 0) needs no special handling; sequencer keeps pulsing en until the match.
REQ-027 load and en never high in the same cycle; d holds captured preset whenever not in IDLE, 0 in IDLE.
REQ-028 All outputs decode from registered state only; no combinational path from start/stop to outputs.

Reset
REQ-029 reset=0 forces IDLE immediately, prescale counter 0, captured registers 0; outputs d=0, load=0, en=0, busy=0, done=0.
REQ-030 Reset assertion mid-run aborts without a done pulse; first start is accepted on the first rising edge after release.

Configuration
REQ-031 Macro SEQ_AUTO_RELOAD_EN defined: DONE -> LOAD (not IDLE); run repeats until stop, which in DONE or LOAD also -> IDLE; busy stays high through DONE.
REQ-032 Macro SEQ_AUTO_RELOAD_EN undefined: behaviour per REQ-024 exactly; no reload logic present.

Structure
REQ-033 Shared package counter_pkg holds the state enum (IDLE, LOAD, RUN, DONE) and constants CNT_W=4, PRE_W=8.
REQ-034 One sub-module, tick_prescaler (clear, enable, divisor in; tick out), implements the prescale counter of REQ-019.

Verification
REQ-035 Reset held 0 for 2 cycles, start=1 -> all outputs 0, no load until reset released.
REQ-036 preset=4'b1010, target=4'b1101, div=0 -> load one cycle with d=4'b1010, then 3 consecutive en pulses, done 1 cycle after q_in=4'b1101.
REQ-037 preset=4'b0000, target=4'b0010, div=3 -> en on every 4th RUN cycle, 2 pulses total, done follows.
REQ-038 preset=4'b1110, target=4'b0001, div=0 -> counter wraps 1111->0000->0001; 3 en pulses, done once.
REQ-039 stop=1 after first en pulse (preset 0, target 9, div 1) -> IDLE next cycle, no done, busy falls.
REQ-040 preset=target=4'b0101 -> zero en pulses, done in the cycle after the first RUN cycle; with SEQ_AUTO_RELOAD_EN, load repeats every 3 cycles until stop.
